// File: rtl/rhythm_pkg.sv
// Shared types, key constants and arithmetic helpers for the rhythm-game scoring path.
package rhythm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_CLEAR = 8'h01;

    // Popcount handles any lane vector up to POP_MAX bits; callers zero-extend into it.
    localparam int unsigned POP_MAX = 512;
    localparam int unsigned POP_W   = $clog2(POP_MAX + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < POP_MAX; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

    // a + b clamped to max; the 33-bit sum cannot wrap for 32-bit operands.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/lane_edge_detect.sv
// Per-lane rising-edge detect of dropper hit/miss levels; a simultaneous hit suppresses the miss.
module lane_edge_detect #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] score_vec,
    input  logic [N-1:0] miss_vec,
    output logic [N-1:0] rise_h,
    output logic [N-1:0] rise_m
);

    logic [N-1:0] prev_score;
    logic [N-1:0] prev_miss;

    // History loads every cycle regardless of game state so stale levels never re-trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_score <= '0;
            prev_miss  <= '0;
        end else begin
            prev_score <= score_vec;
            prev_miss  <= miss_vec;
        end
    end

    assign rise_h = score_vec & ~prev_score;
    assign rise_m = miss_vec & ~prev_miss & ~score_vec;

endmodule

// File: rtl/score_keeper.sv
// Frame-rate judge: turns per-lane hit/miss edges into score, combo and tallies.
// Optional best-score register enabled by defining SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper
    import rhythm_pkg::*;
#(
    parameter int unsigned N_DROPS      = 64,
    parameter int unsigned BASE_PTS     = 10,
    parameter int unsigned COMBO_THRESH = 10,
    parameter logic [7:0]  START_KEY    = KEY_SPACE,
    parameter logic [7:0]  CLEAR_KEY    = KEY_CLEAR
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic [7:0]         keycode_second,
    input  logic [N_DROPS-1:0] score_vec,
    input  logic [N_DROPS-1:0] miss_vec,
    output logic [15:0]        score,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo,
    output logic [7:0]         hits,
    output logic [7:0]         misses,
    output logic               game_over,
    output logic               playing,
    output logic [15:0]        high_score
);

    localparam int unsigned CW = $clog2(N_DROPS + 1);
    localparam int unsigned TW = CW + 2;

    logic [N_DROPS-1:0] rise_h;
    logic [N_DROPS-1:0] rise_m;
    logic [CW-1:0]      nh;
    logic [CW-1:0]      nm;

    state_t        state_q, state_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    combo_q, combo_d;
    logic [7:0]    max_combo_q, max_combo_d;
    logic [7:0]    hits_q, hits_d;
    logic [7:0]    misses_q, misses_d;
    logic [CW-1:0] resolved_q, resolved_d;
    logic          playing_q, playing_d;
    logic          game_over_q, game_over_d;

    logic [31:0]   pts;
    logic [7:0]    combo_inc;
    logic [TW-1:0] total;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic [15:0]   high_score_q, high_score_d;
`endif

    lane_edge_detect #(.N(N_DROPS)) u_edge (
        .clk       (frame_clk),
        .rst       (Reset),
        .score_vec (score_vec),
        .miss_vec  (miss_vec),
        .rise_h    (rise_h),
        .rise_m    (rise_m)
    );

    assign nh = CW'(popcount(POP_MAX'(rise_h)));
    assign nm = CW'(popcount(POP_MAX'(rise_m)));

    // Next-state and counter update; this frame's edges are applied at this same edge.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
        resolved_d  = resolved_q;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
        high_score_d = high_score_q;
`endif

        pts = 32'(nh) * BASE_PTS;
        if (32'(combo_q) >= COMBO_THRESH) begin
            pts = pts << 1;
        end
        combo_inc = 8'(sat_add(32'(combo_q), 32'(nh), 32'd255));
        total     = TW'(resolved_q) + TW'(nh) + TW'(nm);

        case (state_q)
            IDLE: begin
                if (keycode == START_KEY || keycode_second == START_KEY) begin
                    state_d     = PLAYING;
                    score_d     = '0;
                    combo_d     = '0;
                    max_combo_d = '0;
                    hits_d      = '0;
                    misses_d    = '0;
                    resolved_d  = '0;
                end
            end
            PLAYING: begin
                score_d     = 16'(sat_add(32'(score_q), pts, 32'h0000_FFFF));
                hits_d      = 8'(sat_add(32'(hits_q), 32'(nh), 32'd255));
                misses_d    = 8'(sat_add(32'(misses_q), 32'(nm), 32'd255));
                max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
                combo_d     = (nm != '0) ? 8'd0 : combo_inc;
                resolved_d  = resolved_q + nh + nm;
                if (total == TW'(N_DROPS)) begin
                    state_d = DONE;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
                    if (score_d > high_score_q) begin
                        high_score_d = score_d;
                    end
`endif
                end
            end
            DONE: begin
                if (keycode == CLEAR_KEY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        playing_d   = (state_d == PLAYING);
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            resolved_q  <= '0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
            high_score_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            resolved_q  <= resolved_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
            high_score_q <= high_score_d;
`endif
        end
    end

    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;
    assign hits      = hits_q;
    assign misses    = misses_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    assign high_score = high_score_q;
`else
    assign high_score = 16'h0000;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a 4-lane game instance plus a 260-lane instance for saturation.
module tb_score_keeper;

    typedef struct packed {
        logic [15:0] score;
        logic [7:0]  combo;
        logic [7:0]  max_combo;
        logic [7:0]  hits;
        logic [7:0]  misses;
        logic        game_over;
        logic        playing;
        logic [15:0] high_score;
    } snap_t;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-lane game instance
    logic        rst = 1'b1;
    logic [7:0]  kc = 8'h00;
    logic [7:0]  kc2 = 8'h00;
    logic [3:0]  sv = 4'h0;
    logic [3:0]  mv = 4'h0;
    logic [15:0] a_score, a_hs;
    logic [7:0]  a_combo, a_max, a_hits, a_misses;
    logic        a_go, a_pl;
    snap_t       obs_a;

    // 260-lane saturation instance
    logic          rst_b = 1'b1;
    logic [7:0]    kc_b = 8'h00;
    logic [7:0]    kc2_b = 8'h00;
    logic [259:0]  sv_b = '0;
    logic [259:0]  mv_b = '0;
    logic [15:0]   b_score, b_hs;
    logic [7:0]    b_combo, b_max, b_hits, b_misses;
    logic          b_go, b_pl;
    snap_t         obs_b;

    int    n_run  = 0;
    int    n_fail = 0;
    snap_t q[$];
    snap_t want;

    score_keeper #(.N_DROPS(4), .BASE_PTS(10), .COMBO_THRESH(2)) dut (
        .frame_clk(clk), .Reset(rst), .keycode(kc), .keycode_second(kc2),
        .score_vec(sv), .miss_vec(mv), .score(a_score), .combo(a_combo),
        .max_combo(a_max), .hits(a_hits), .misses(a_misses), .game_over(a_go),
        .playing(a_pl), .high_score(a_hs)
    );

    score_keeper #(.N_DROPS(260), .BASE_PTS(300), .COMBO_THRESH(2)) dut_sat (
        .frame_clk(clk), .Reset(rst_b), .keycode(kc_b), .keycode_second(kc2_b),
        .score_vec(sv_b), .miss_vec(mv_b), .score(b_score), .combo(b_combo),
        .max_combo(b_max), .hits(b_hits), .misses(b_misses), .game_over(b_go),
        .playing(b_pl), .high_score(b_hs)
    );

    assign obs_a = {a_score, a_combo, a_max, a_hits, a_misses, a_go, a_pl, a_hs};
    assign obs_b = {b_score, b_combo, b_max, b_hits, b_misses, b_go, b_pl, b_hs};

    function automatic snap_t mk(input int unsigned s, input int unsigned c, input int unsigned m,
                                 input int unsigned h, input int unsigned ms, input bit go,
                                 input bit pl, input int unsigned hs);
        snap_t r;
        r.score      = 16'(s);
        r.combo      = 8'(c);
        r.max_combo  = 8'(m);
        r.hits       = 8'(h);
        r.misses     = 8'(ms);
        r.game_over  = go;
        r.playing    = pl;
        r.high_score = HS_EN ? 16'(hs) : 16'h0000;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; kc = 8'h00; kc2 = 8'h00; sv = 4'h0; mv = 4'h0;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        want = q.pop_front(); n_run++;
        if (obs_a !== want) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs_a, want);
        end
        rst = 1'b0;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        want = q.pop_front(); n_run++;
        if (obs_a !== want) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_a, want);
        end
    endtask

    task automatic test_start();
        kc = 8'h2C;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
        @(posedge clk); #1;
        kc = 8'h00;
        want = q.pop_front(); n_run++;
        if (obs_a !== want) begin
            n_fail++;
            $display("FAIL start: got %h expected %h", obs_a, want);
        end
    endtask

    task automatic test_hits();
        logic [3:0] sv_t [3];
        snap_t      e [3];
        sv_t[0] = 4'b0001; e[0] = mk(10, 1, 1, 1, 0, 0, 1, 0);
        sv_t[1] = 4'b0011; e[1] = mk(20, 2, 2, 2, 0, 0, 1, 0);
        sv_t[2] = 4'b0111; e[2] = mk(40, 3, 3, 3, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            sv = sv_t[i];
            q.push_back(e[i]);
            @(posedge clk); #1;
            want = q.pop_front(); n_run++;
            if (obs_a !== want) begin
                n_fail++;
                $display("FAIL hits step %0d: got %h expected %h", i, obs_a, want);
            end
        end
    endtask

    task automatic test_miss_done();
        mv = 4'b1000;
        q.push_back(mk(40, 0, 3, 3, 1, 1, 0, 40));
        @(posedge clk); #1;
        want = q.pop_front(); n_run++;
        if (obs_a !== want) begin
            n_fail++;
            $display("FAIL miss_done: got %h expected %h", obs_a, want);
        end
        kc = 8'h2C;
        q.push_back(mk(40, 0, 3, 3, 1, 1, 0, 40));
        @(posedge clk); #1;
        kc = 8'h00;
        want = q.pop_front(); n_run++;
        if (obs_a !== want) begin
            n_fail++;
            $display("FAIL start_in_done: got %h expected %h", obs_a, want);
        end
    endtask

    task automatic test_clear_restart();
        logic [7:0] kc_t [3];
        snap_t      e [3];
        kc_t[0] = 8'h01; e[0] = mk(40, 0, 3, 3, 1, 0, 0, 40);
        kc_t[1] = 8'h2C; e[1] = mk(0, 0, 0, 0, 0, 0, 1, 40);
        kc_t[2] = 8'h00; e[2] = mk(0, 0, 0, 0, 0, 0, 1, 40);
        for (int i = 0; i < 3; i++) begin
            kc = kc_t[i];
            q.push_back(e[i]);
            @(posedge clk); #1;
            want = q.pop_front(); n_run++;
            if (obs_a !== want) begin
                n_fail++;
                $display("FAIL clear_restart step %0d: got %h expected %h", i, obs_a, want);
            end
        end
    endtask

    task automatic test_multi_hit();
        logic [3:0] sv_t [4];
        logic [3:0] mv_t [4];
        snap_t      e [4];
        sv_t[0] = 4'b0000; mv_t[0] = 4'b0000; e[0] = mk(0, 0, 0, 0, 0, 0, 1, 40);
        sv_t[1] = 4'b0011; mv_t[1] = 4'b0000; e[1] = mk(20, 2, 2, 2, 0, 0, 1, 40);
        sv_t[2] = 4'b0111; mv_t[2] = 4'b0100; e[2] = mk(40, 3, 3, 3, 0, 0, 1, 40);
        sv_t[3] = 4'b0111; mv_t[3] = 4'b1100; e[3] = mk(40, 0, 3, 3, 1, 1, 0, 40);
        for (int i = 0; i < 4; i++) begin
            sv = sv_t[i];
            mv = mv_t[i];
            q.push_back(e[i]);
            @(posedge clk); #1;
            want = q.pop_front(); n_run++;
            if (obs_a !== want) begin
                n_fail++;
                $display("FAIL multi_hit step %0d: got %h expected %h", i, obs_a, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] kc_t [5];
        logic [7:0] kc2_t [5];
        logic [3:0] sv_t [5];
        logic       rst_t [5];
        snap_t      e [5];
        kc_t[0] = 8'h01; kc2_t[0] = 8'h00; sv_t[0] = 4'b0000; rst_t[0] = 1'b0; e[0] = mk(40, 0, 3, 3, 1, 0, 0, 40);
        kc_t[1] = 8'h00; kc2_t[1] = 8'h2C; sv_t[1] = 4'b0000; rst_t[1] = 1'b0; e[1] = mk(0, 0, 0, 0, 0, 0, 1, 40);
        kc_t[2] = 8'h01; kc2_t[2] = 8'h00; sv_t[2] = 4'b0001; rst_t[2] = 1'b0; e[2] = mk(10, 1, 1, 1, 0, 0, 1, 40);
        kc_t[3] = 8'h00; kc2_t[3] = 8'h00; sv_t[3] = 4'b0011; rst_t[3] = 1'b1; e[3] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        kc_t[4] = 8'h00; kc2_t[4] = 8'h00; sv_t[4] = 4'b0011; rst_t[4] = 1'b0; e[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        mv = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            kc  = kc_t[i];
            kc2 = kc2_t[i];
            sv  = sv_t[i];
            rst = rst_t[i];
            q.push_back(e[i]);
            @(posedge clk); #1;
            want = q.pop_front(); n_run++;
            if (obs_a !== want) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, obs_a, want);
            end
        end
    endtask

    task automatic test_saturation();
        logic [259:0] sv_t [5];
        logic [259:0] mv_t [5];
        logic         rst_t [5];
        logic [7:0]   kc_t [5];
        snap_t        e [5];
        logic [259:0] low255;
        logic [259:0] low256;
        logic [259:0] top4;
        low255 = {5'b0, {255{1'b1}}};
        low256 = {4'b0, {256{1'b1}}};
        top4   = {4'b1111, 256'b0};
        rst_t[0] = 1'b1; kc_t[0] = 8'h00; sv_t[0] = '0;     mv_t[0] = '0;   e[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst_t[1] = 1'b0; kc_t[1] = 8'h2C; sv_t[1] = '0;     mv_t[1] = '0;   e[1] = mk(0, 0, 0, 0, 0, 0, 1, 0);
        rst_t[2] = 1'b0; kc_t[2] = 8'h00; sv_t[2] = low255; mv_t[2] = '0;   e[2] = mk(16'hFFFF, 255, 255, 255, 0, 0, 1, 0);
        rst_t[3] = 1'b0; kc_t[3] = 8'h00; sv_t[3] = low256; mv_t[3] = '0;   e[3] = mk(16'hFFFF, 255, 255, 255, 0, 0, 1, 0);
        rst_t[4] = 1'b0; kc_t[4] = 8'h00; sv_t[4] = low256; mv_t[4] = top4; e[4] = mk(16'hFFFF, 0, 255, 255, 4, 1, 0, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            rst_b = rst_t[i];
            kc_b  = kc_t[i];
            sv_b  = sv_t[i];
            mv_b  = mv_t[i];
            q.push_back(e[i]);
            @(posedge clk); #1;
            want = q.pop_front(); n_run++;
            if (obs_b !== want) begin
                n_fail++;
                $display("FAIL saturation step %0d: got %h expected %h", i, obs_b, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hits();
        test_miss_done();
        test_clear_restart();
        test_multi_hit();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
